hq_tod_tx: RTL and testbench

HQ_TOD_TX -- requirements
Module: hq_tod_tx

---
 rtl/hq_tod_tx_pkg.sv | 62 ++++++
 rtl/hq_tod_tx_bin2bcd.sv | 27 ++
 rtl/hq_tod_tx.sv | 191 +++++++++++++++++++
 tb/tb_hq_tod_tx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hq_tod_tx_pkg.sv
// ---------------------------------------------------------------------------
// hq_pkg -- shared definitions for the HaveQuick time-of-day transmitter.
//   PREAMBLE        16-bit frame sync word, sent MSB first
//   N_DIGITS        BCD digits per frame (11)
//   FRAME_BITS      total frame length in bits (16 preamble + 11 * 5)
//   *_MAX           inclusive upper limits for the UTC input fields
//   hq_state_e      transmitter FSM state encoding
//   hq_tod_t        packed UTC field bundle (yy, doy, hh, mm, ss)
//   hq_in_range()   field range check
//   hq_build_frame()  assembles preamble + digits with odd parity
// ---------------------------------------------------------------------------
package hq_pkg;

    localparam logic [15:0] PREAMBLE   = 16'hEB90;
    localparam int unsigned N_DIGITS   = 11;
    localparam int unsigned PRE_BITS   = 16;
    localparam int unsigned FRAME_BITS = 71;

    localparam logic [5:0] HH_MAX  = 6'd23;
    localparam logic [5:0] MM_MAX  = 6'd59;
    localparam logic [5:0] SS_MAX  = 6'd60;
    localparam logic [8:0] DOY_MAX = 9'd366;
    localparam logic [6:0] YY_MAX  = 7'd99;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PRE,
        DATA,
        GAP
    } hq_state_e;

    typedef struct packed {
        logic [6:0] yy;
        logic [8:0] doy;
        logic [5:0] hh;
        logic [5:0] mm;
        logic [5:0] ss;
    } hq_tod_t;

    function automatic logic hq_in_range(input hq_tod_t t);
        return (t.hh <= HH_MAX) && (t.mm <= MM_MAX) && (t.ss <= SS_MAX) &&
               (t.doy != 9'd0) && (t.doy <= DOY_MAX) && (t.yy <= YY_MAX);
    endfunction

    // digits[43:40] is the first digit on the line; each digit is followed
    // by a parity bit that makes the 5-bit group carry an odd number of ones.
    function automatic logic [FRAME_BITS-1:0] hq_build_frame(
        input logic [4*N_DIGITS-1:0] digits
    );
        logic [FRAME_BITS-1:0] f;
        logic [3:0]            d;
        f = '0;
        f[FRAME_BITS-1 -: PRE_BITS] = PREAMBLE;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            d = digits[4*(N_DIGITS-1-k) +: 4];
            f[FRAME_BITS-PRE_BITS-1-5*k -: 5] = {d, ~^d};
        end
        return f;
    endfunction

endpackage

// File: rtl/hq_tod_tx_bin2bcd.sv
// ---------------------------------------------------------------------------
// hq_bin2bcd -- combinational 9-bit binary to 3-digit BCD converter
// (shift-and-add-3). Exact for the full 0..511 input range.
//   bin_i  [8:0]   binary input
//   bcd_o  [11:0]  {hundreds, tens, units}
// ---------------------------------------------------------------------------
module hq_bin2bcd (
    input  logic [8:0]  bin_i,
    output logic [11:0] bcd_o
);

    logic [11:0] acc;

    always_comb begin
        acc = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            for (int unsigned d = 0; d < 3; d++) begin
                if (acc[4*d +: 4] >= 4'd5) begin
                    acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
                end
            end
            acc = {acc[10:0], bin_i[8-i]};
        end
        bcd_o = acc;
    end

endmodule

// File: rtl/hq_tod_tx.sv
// ---------------------------------------------------------------------------
// hq_tod_tx -- HaveQuick time-of-day serial transmitter.
// Captures a UTC strobe, converts the fields to 11 BCD digits and sends
// preamble 0xEB90 followed by 11 x (4-bit digit + odd parity), MSB first,
// BIT_DIV clocks per bit, then holds the line idle for GAP_BITS bit-times.
// A one-deep pending buffer holds a strobe that arrives while busy.
//
// Parameters: BIT_DIV (clocks per bit, even, >= 4), GAP_BITS (>= 1).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   tod_valid           one-cycle strobe qualifying hh/mm/ss/doy/yy
//   hh, mm, ss, doy, yy binary UTC fields
//   hq_data             serial line (idle 0)
//   hq_frame            high while preamble/data bits are on the line
//   busy                high from capture to end of gap
//   done                pulse after the last gap cycle
//   range_err           pulse for a strobe rejected on range
//   overrun             pulse when the pending buffer is overwritten
// Build option: define HQ_MANCHESTER_EN for Manchester bit coding
// (1 = high/low, 0 = low/high); NRZ otherwise. Timing is identical.
// ---------------------------------------------------------------------------
module hq_tod_tx
    import hq_pkg::*;
#(
    parameter int unsigned BIT_DIV  = 10000,
    parameter int unsigned GAP_BITS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tod_valid,
    input  logic [5:0] hh,
    input  logic [5:0] mm,
    input  logic [5:0] ss,
    input  logic [8:0] doy,
    input  logic [6:0] yy,
    output logic       hq_data,
    output logic       hq_frame,
    output logic       busy,
    output logic       done,
    output logic       range_err,
    output logic       overrun
);

    localparam int unsigned CW      = $clog2(BIT_DIV);
    localparam int unsigned GAP_CYC = GAP_BITS * BIT_DIV;
    localparam int unsigned GW      = $clog2(GAP_CYC);

    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_DIV - 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(BIT_DIV / 2 - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    localparam logic [6:0]    BIT_LAST = 7'(FRAME_BITS - 1);
    localparam logic [6:0]    PRE_LAST = 7'(PRE_BITS - 1);

    hq_state_e             state_q;
    hq_tod_t               cur_q;
    hq_tod_t               pend_q;
    logic                  pend_v_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [6:0]            bidx_q;
    logic [CW-1:0]         cnt_q;
    logic [GW-1:0]         gcnt_q;

    hq_tod_t               tod_in;
    logic                  strobe_ok;
    logic                  strobe_bad;
    logic                  gap_exit;
    logic [FRAME_BITS-1:0] frame_d;

    logic [11:0] yy_bcd, doy_bcd, hh_bcd, mm_bcd, ss_bcd;
    logic        unused_hundreds;

    assign tod_in     = '{yy: yy, doy: doy, hh: hh, mm: mm, ss: ss};
    assign strobe_ok  = tod_valid &  hq_in_range(tod_in);
    assign strobe_bad = tod_valid & ~hq_in_range(tod_in);
    assign gap_exit   = (state_q == GAP) && (gcnt_q == GAP_LAST);

    hq_bin2bcd u_bcd_yy  (.bin_i({2'b00, cur_q.yy}),  .bcd_o(yy_bcd));
    hq_bin2bcd u_bcd_doy (.bin_i(cur_q.doy),          .bcd_o(doy_bcd));
    hq_bin2bcd u_bcd_hh  (.bin_i({3'b000, cur_q.hh}), .bcd_o(hh_bcd));
    hq_bin2bcd u_bcd_mm  (.bin_i({3'b000, cur_q.mm}), .bcd_o(mm_bcd));
    hq_bin2bcd u_bcd_ss  (.bin_i({3'b000, cur_q.ss}), .bcd_o(ss_bcd));

    // Hundreds digit is always zero for the two-digit fields.
    assign unused_hundreds = ^{yy_bcd[11:8], hh_bcd[11:8], mm_bcd[11:8], ss_bcd[11:8]};

    assign frame_d = hq_build_frame({yy_bcd[7:0], doy_bcd, hh_bcd[7:0],
                                     mm_bcd[7:0], ss_bcd[7:0]});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
            shift_q   <= '0;
            bidx_q    <= '0;
            cnt_q     <= '0;
            gcnt_q    <= '0;
            hq_data   <= 1'b0;
            hq_frame  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            range_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done      <= 1'b0;
            overrun   <= 1'b0;
            range_err <= strobe_bad;

            case (state_q)
                IDLE: begin
                    if (strobe_ok) begin
                        cur_q   <= tod_in;
                        busy    <= 1'b1;
                        state_q <= LOAD;
                    end
                end

                LOAD: begin
                    shift_q  <= frame_d;
                    hq_data  <= frame_d[FRAME_BITS-1];
                    hq_frame <= 1'b1;
                    cnt_q    <= '0;
                    bidx_q   <= '0;
                    state_q  <= PRE;
                end

                PRE, DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (bidx_q == BIT_LAST) begin
                            hq_data  <= 1'b0;
                            hq_frame <= 1'b0;
                            gcnt_q   <= '0;
                            state_q  <= GAP;
                        end else begin
                            shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
                            bidx_q  <= bidx_q + 7'd1;
                            hq_data <= shift_q[FRAME_BITS-2];
                            if (bidx_q == PRE_LAST) begin
                                state_q <= DATA;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`ifdef HQ_MANCHESTER_EN
                        // Output is registered, so invert one cycle early
                        // to land the transition exactly at mid-bit.
                        hq_data <= (cnt_q >= HALF_M1) ? ~shift_q[FRAME_BITS-1]
                                                      :  shift_q[FRAME_BITS-1];
`else
                        hq_data <= shift_q[FRAME_BITS-1];
`endif
                    end
                end

                GAP: begin
                    if (gap_exit) begin
                        done <= 1'b1;
                        // A strobe on the exit cycle is newer than any
                        // pending entry and goes straight to LOAD.
                        if (strobe_ok) begin
                            cur_q    <= tod_in;
                            overrun  <= pend_v_q;
                            pend_v_q <= 1'b0;
                            state_q  <= LOAD;
                        end else if (pend_v_q) begin
                            cur_q    <= pend_q;
                            pend_v_q <= 1'b0;
                            state_q  <= LOAD;
                        end else begin
                            busy    <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        gcnt_q <= gcnt_q + 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase

            if (strobe_ok && (state_q != IDLE) && !gap_exit) begin
                pend_q   <= tod_in;
                pend_v_q <= 1'b1;
                overrun  <= pend_v_q;
            end
        end
    end

endmodule

// File: tb/tb_hq_tod_tx.sv
// ---------------------------------------------------------------------------
// tb_hq_tod_tx -- directed bench for hq_tod_tx with BIT_DIV=4, GAP_BITS=4.
// Expected frames are built from the UTC fields with decimal arithmetic and
// queued when a strobe is driven; each transmitted frame is popped and
// compared bit-cycle by bit-cycle (NRZ or Manchester per HQ_MANCHESTER_EN).
// ---------------------------------------------------------------------------
module tb_hq_tod_tx;

    localparam int BIT_DIV  = 4;
    localparam int GAP_BITS = 4;
    localparam int HALF     = BIT_DIV / 2;
    localparam int GAP_CYC  = GAP_BITS * BIT_DIV;

    typedef struct packed {
        logic [6:0] yy;
        logic [8:0] doy;
        logic [5:0] hh;
        logic [5:0] mm;
        logic [5:0] ss;
    } tod_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tod_valid = 1'b0;
    logic [5:0] hh = '0, mm = '0, ss = '0;
    logic [8:0] doy = '0;
    logic [6:0] yy = '0;
    logic       hq_data, hq_frame, busy, done, range_err, overrun;

    hq_tod_tx #(.BIT_DIV(BIT_DIV), .GAP_BITS(GAP_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .tod_valid(tod_valid),
        .hh(hh), .mm(mm), .ss(ss), .doy(doy), .yy(yy),
        .hq_data(hq_data), .hq_frame(hq_frame), .busy(busy),
        .done(done), .range_err(range_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [70:0] exp_q[$];
    bit          m_busy   = 1'b0;
    bit          m_pend_v = 1'b0;
    tod_t        m_pend   = '0;

    task automatic check(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [70:0] frame_from_digits(input logic [43:0] dg);
        logic [70:0] f;
        logic [3:0]  d;
        int          ones;
        f = '0;
        f[70:55] = 16'hEB90;
        for (int k = 0; k < 11; k++) begin
            d    = dg[43-4*k -: 4];
            ones = d[0] + d[1] + d[2] + d[3];
            f[54-5*k -: 4] = d;
            f[50-5*k]      = (ones % 2 == 0);
        end
        return f;
    endfunction

    function automatic logic [70:0] fields_frame(input tod_t t);
        int y, dy, h, m, s;
        y = t.yy; dy = t.doy; h = t.hh; m = t.mm; s = t.ss;
        return frame_from_digits({4'(y / 10), 4'(y % 10),
                                  4'(dy / 100), 4'((dy / 10) % 10), 4'(dy % 10),
                                  4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                                  4'(s / 10), 4'(s % 10)});
    endfunction

    function automatic bit in_range(input tod_t t);
        int y, dy, h, m, s;
        y = t.yy; dy = t.doy; h = t.hh; m = t.mm; s = t.ss;
        return (h < 24) && (m < 60) && (s < 61) && (dy >= 1) && (dy < 367) && (y < 100);
    endfunction

    function automatic logic exp_level(input logic b, input int c);
`ifdef HQ_MANCHESTER_EN
        return (c < HALF) ? b : ~b;
`else
        return (c < BIT_DIV) ? b : 1'bx;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a strobe for the next edge and update the scoreboard model.
    task automatic apply(input tod_t f);
        yy = f.yy; doy = f.doy; hh = f.hh; mm = f.mm; ss = f.ss;
        tod_valid = 1'b1;
        if (in_range(f)) begin
            if (!m_busy) begin
                exp_q.push_back(fields_frame(f));
                m_busy = 1'b1;
            end else begin
                m_pend   = f;
                m_pend_v = 1'b1;
            end
        end
    endtask

    // Called at the first bit cycle of a frame; ends at the first gap cycle.
    task automatic run_frame(input int inj0, input tod_t f0, input int inj1, input tod_t f1,
                             input int exp_ovr, input int exp_rerr);
        logic [70:0] e, rx;
        int          werr, ovr, rerr, idx;
        werr = 0; ovr = 0; rerr = 0; rx = '0; e = '0;
        check("sb_nonempty", 71'(exp_q.size() != 0), 71'd1);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        for (int i = 0; i < 71; i++) begin
            for (int c = 0; c < BIT_DIV; c++) begin
                idx = i * BIT_DIV + c;
                if (c == 0) rx[70-i] = hq_data;
                if (hq_data !== exp_level(e[70-i], c) || hq_frame !== 1'b1) werr++;
                if (overrun === 1'b1) ovr++;
                if (range_err === 1'b1) rerr++;
                tod_valid = 1'b0;
                if (idx == inj0) apply(f0);
                if (idx == inj1) apply(f1);
                tick();
            end
        end
        tod_valid = 1'b0;
        check("frame_bits", rx, e);
        check("frame_wave_errs", 71'(werr), 71'd0);
        check("frame_overruns", 71'(ovr), 71'(exp_ovr));
        check("frame_range_errs", 71'(rerr), 71'(exp_rerr));
    endtask

    // Called at the first gap cycle; ends at the cycle where done is high.
    task automatic gap_end(input bit inj, input tod_t f, input logic exp_ovr, input logic exp_busy);
        int bad;
        bad = 0;
        for (int g = 0; g < GAP_CYC; g++) begin
            if (hq_data !== 1'b0 || hq_frame !== 1'b0 || busy !== 1'b1 || done !== 1'b0) bad++;
            tod_valid = 1'b0;
            if (inj && g == GAP_CYC - 1) apply(f);
            tick();
        end
        tod_valid = 1'b0;
        if (m_pend_v) begin
            exp_q.push_back(fields_frame(m_pend));
            m_pend_v = 1'b0;
        end else begin
            m_busy = 1'b0;
        end
        check("gap_idle_errs", 71'(bad), 71'd0);
        check("done_pulse", 71'(done), 71'd1);
        check("gap_exit_overrun", 71'(overrun), 71'(exp_ovr));
        check("busy_after_gap", 71'(busy), 71'(exp_busy));
    endtask

    tod_t bad_tab[6];
    tod_t fa, fb, fc, fd, fe, fbad;
    int   quiet;

    initial begin
        bad_tab[0] = {7'd26,  9'd45,  6'd24, 6'd7,  6'd59};
        bad_tab[1] = {7'd26,  9'd45,  6'd13, 6'd60, 6'd59};
        bad_tab[2] = {7'd26,  9'd45,  6'd13, 6'd7,  6'd61};
        bad_tab[3] = {7'd26,  9'd0,   6'd13, 6'd7,  6'd59};
        bad_tab[4] = {7'd26,  9'd367, 6'd13, 6'd7,  6'd59};
        bad_tab[5] = {7'd100, 9'd45,  6'd13, 6'd7,  6'd59};
        fa   = {7'd26, 9'd1,   6'd0,  6'd0,  6'd0};
        fb   = {7'd1,  9'd100, 6'd12, 6'd30, 6'd30};
        fc   = {7'd5,  9'd365, 6'd22, 6'd58, 6'd1};
        fd   = {7'd0,  9'd10,  6'd1,  6'd2,  6'd3};
        fe   = {7'd42, 9'd200, 6'd11, 6'd11, 6'd11};
        fbad = {7'd0,  9'd1,   6'd30, 6'd0,  6'd0};

        // Reset
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_outputs", 71'({hq_data, hq_frame, busy, done, range_err, overrun}), 71'd0);
        rst_n = 1'b1;
        tick();

        // Basic frame with fixed digit expectations
        yy = 7'd26; doy = 9'd45; hh = 6'd13; mm = 6'd7; ss = 6'd59;
        tod_valid = 1'b1;
        exp_q.push_back(frame_from_digits(44'h26045130759));
        m_busy = 1'b1;
        tick();
        tod_valid = 1'b0;
        check("busy_on_capture", 71'(busy), 71'd1);
        check("load_no_frame", 71'(hq_frame), 71'd0);
        tick();
        check("first_bit_latency", 71'(hq_frame), 71'd1);
        run_frame(-1, '0, -1, '0, 0, 0);
        gap_end(1'b0, '0, 1'b0, 1'b0);
        tick();
        check("done_one_cycle", 71'(done), 71'd0);

        // Range rejection, each limit just exceeded
        for (int k = 0; k < 6; k++) begin
            apply(bad_tab[k]);
            tick();
            tod_valid = 1'b0;
            check("range_err_pulse", 71'(range_err), 71'd1);
            check("range_no_busy", 71'(busy), 71'd0);
            tick();
        end
        check("range_err_clears", 71'(range_err), 71'd0);
        quiet = 0;
        repeat (8) begin
            if (range_err !== 1'b0 || busy !== 1'b0 || hq_data !== 1'b0) quiet++;
            tick();
        end
        check("range_stays_idle", 71'(quiet), 71'd0);

        // All fields at their upper limits, ss=60 included
        apply({7'd99, 9'd366, 6'd23, 6'd59, 6'd60});
        tick();
        tod_valid = 1'b0;
        tick();
        check("limit_frame_start", 71'(hq_frame), 71'd1);
        run_frame(-1, '0, -1, '0, 0, 0);
        gap_end(1'b0, '0, 1'b0, 1'b0);
        tick();

        // Back-to-back strobes: B pending, C overwrites it
        apply(fa);
        tick();
        tod_valid = 1'b0;
        tick();
        check("chain_a_start", 71'(hq_frame), 71'd1);
        run_frame(40, fb, 120, fc, 1, 0);
        gap_end(1'b0, '0, 1'b0, 1'b1);
        tick();
        check("chain_c_start", 71'(hq_frame), 71'd1);
        // D pending, out-of-range ignored, E on the gap-exit cycle wins
        run_frame(100, fd, 200, fbad, 0, 1);
        gap_end(1'b1, fe, 1'b1, 1'b1);
        tick();
        check("chain_e_start", 71'(hq_frame), 71'd1);
        run_frame(-1, '0, -1, '0, 0, 0);
        gap_end(1'b0, '0, 1'b0, 1'b0);
        tick();
        check("chain_idle", 71'({busy, done}), 71'd0);

        // Reset during data bit 20 (frame bit 36)
        apply(fa);
        tick();
        tod_valid = 1'b0;
        tick();
        repeat (36 * BIT_DIV + 1) tick();
        check("mid_frame_active", 71'({hq_frame, busy}), 71'b11);
        rst_n = 1'b0;
        tick();
        check("reset_mid_frame", 71'({hq_data, hq_frame, busy, done, range_err, overrun}), 71'd0);
        rst_n = 1'b1;
        exp_q.delete();
        m_busy = 1'b0;
        m_pend_v = 1'b0;
        quiet = 0;
        repeat (400) begin
            if (done !== 1'b0 || busy !== 1'b0 || hq_data !== 1'b0 || hq_frame !== 1'b0) quiet++;
            tick();
        end
        check("no_resume_after_reset", 71'(quiet), 71'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
